// File: rtl/guard_pkg.sv
// Shared types for the guard patrol and walk animator: direction codes, patrol legs, sprite size.
package guard_pkg;

  localparam int unsigned SPRITE_W = 21;

  typedef enum logic [2:0] {
    DIR_LEFT  = 3'b000,
    DIR_RIGHT = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_UP    = 3'b011,
    DIR_NONE  = 3'b111
  } dir_t;

  typedef enum logic [2:0] {
    WALK_RIGHT,
    WALK_DOWN,
    WALK_LEFT,
    WALK_UP,
    PAUSE
  } patrol_state_t;

  function automatic patrol_state_t opposite_leg(input patrol_state_t s);
    case (s)
      WALK_RIGHT: return WALK_LEFT;
      WALK_LEFT:  return WALK_RIGHT;
      WALK_DOWN:  return WALK_UP;
      WALK_UP:    return WALK_DOWN;
      default:    return s;
    endcase
  endfunction

  // Leg entered after reaching the corner that ends leg s.
  function automatic patrol_state_t following_leg(input patrol_state_t s, input logic ccw);
    case (s)
      WALK_RIGHT: return ccw ? WALK_UP    : WALK_DOWN;
      WALK_DOWN:  return ccw ? WALK_RIGHT : WALK_LEFT;
      WALK_LEFT:  return ccw ? WALK_DOWN  : WALK_UP;
      WALK_UP:    return ccw ? WALK_LEFT  : WALK_RIGHT;
      default:    return WALK_RIGHT;
    endcase
  endfunction

  function automatic dir_t leg_dir(input patrol_state_t s);
    case (s)
      WALK_RIGHT: return DIR_RIGHT;
      WALK_DOWN:  return DIR_DOWN;
      WALK_LEFT:  return DIR_LEFT;
      WALK_UP:    return DIR_UP;
      default:    return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/guard_axis_step.sv
// One-axis step toward a limit with clamping; 11-bit arithmetic so no 10-bit wrap occurs.
module guard_axis_step (
  input  logic [9:0] pos,
  input  logic [9:0] limit,
  input  logic [3:0] step,
  input  logic       dec,
  output logic [9:0] next_pos,
  output logic       at_limit
);

  logic [10:0] pos_w;
  logic [10:0] lim_w;
  logic [10:0] step_w;

  always_comb begin
    pos_w  = {1'b0, pos};
    lim_w  = {1'b0, limit};
    step_w = {7'b0, step};
    if (dec) at_limit = (pos_w <= lim_w + step_w);
    else     at_limit = (pos_w + step_w >= lim_w);
    if (at_limit) next_pos = limit;
    else if (dec) next_pos = pos - step_w[9:0];
    else          next_pos = pos + step_w[9:0];
  end

endmodule

// File: rtl/guard_patrol.sv
// Guard patrol motion: clockwise rectangular walk with corner pauses, one step per frame tick.
// Optional GUARD_PATROL_REVERSE_EN adds a 'reverse' input that flips the patrol to counter-clockwise.
module guard_patrol
  import guard_pkg::*;
#(
  parameter logic [9:0] X_MIN        = 10'd100,
  parameter logic [9:0] X_MAX        = 10'd400,
  parameter logic [9:0] Y_MIN        = 10'd80,
  parameter logic [9:0] Y_MAX        = 10'd300,
  parameter logic [3:0] STEP         = 4'd2,
  parameter logic [7:0] PAUSE_FRAMES = 8'd30
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       freeze,
`ifdef GUARD_PATROL_REVERSE_EN
  input  logic       reverse,
`endif
  output logic [9:0] GuardX,
  output logic [9:0] GuardY,
  output dir_t       direction_guard,
  output logic       corner_pulse,
  output logic [7:0] lap_count
);

  patrol_state_t state, next_leg, leg;
  logic [7:0]    pause_cnt;
  logic          ccw;
  logic          adv, rev_hit, ccw_eff, horiz, hit, lap_hit;
  logic          x_at, y_at;
  logic [9:0]    x_next, y_next;

  assign adv = frame_tick & enable & ~freeze;

`ifdef GUARD_PATROL_REVERSE_EN
  assign rev_hit = adv & reverse & (state != PAUSE);
`else
  assign rev_hit = 1'b0;
`endif

  // A reverse flips the leg before the move so the guard steps the new way on the same tick.
  assign leg     = rev_hit ? opposite_leg(state) : state;
  assign ccw_eff = ccw ^ rev_hit;
  assign horiz   = (leg == WALK_RIGHT) || (leg == WALK_LEFT);
  assign hit     = horiz ? x_at : y_at;
  assign lap_hit = hit && (ccw_eff ? (leg == WALK_LEFT) : (leg == WALK_UP));

  guard_axis_step u_x_step (
    .pos      (GuardX),
    .limit    ((leg == WALK_LEFT) ? X_MIN : X_MAX),
    .step     (STEP),
    .dec      (leg == WALK_LEFT),
    .next_pos (x_next),
    .at_limit (x_at)
  );

  guard_axis_step u_y_step (
    .pos      (GuardY),
    .limit    ((leg == WALK_UP) ? Y_MIN : Y_MAX),
    .step     (STEP),
    .dec      (leg == WALK_UP),
    .next_pos (y_next),
    .at_limit (y_at)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state           <= WALK_RIGHT;
      next_leg        <= WALK_RIGHT;
      pause_cnt       <= 8'd0;
      ccw             <= 1'b0;
      GuardX          <= X_MIN;
      GuardY          <= Y_MIN;
      direction_guard <= DIR_NONE;
      corner_pulse    <= 1'b0;
      lap_count       <= 8'd0;
    end else begin
      corner_pulse    <= 1'b0;
      direction_guard <= (enable && !freeze && state != PAUSE) ? leg_dir(state) : DIR_NONE;
      if (adv) begin
        if (state == PAUSE) begin
          if (pause_cnt == PAUSE_FRAMES - 8'd1) begin
            state     <= next_leg;
            pause_cnt <= 8'd0;
          end else begin
            pause_cnt <= pause_cnt + 8'd1;
          end
        end else begin
          ccw <= ccw_eff;
          if (horiz) GuardX <= x_next;
          else       GuardY <= y_next;
          if (hit) begin
            corner_pulse <= 1'b1;
            if (lap_hit) lap_count <= lap_count + 8'd1;
            if (PAUSE_FRAMES == 8'd0) begin
              state <= following_leg(leg, ccw_eff);
            end else begin
              state    <= PAUSE;
              next_leg <= following_leg(leg, ccw_eff);
            end
          end else begin
            state <= leg;
          end
        end
      end
    end
  end

endmodule
